if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 11 +
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// The fetch stage holds the master side, which drives the request and address.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register.
// The stage tolerates variable-latency instruction memory and honours a single
// branch delay slot: a redirect seen in decode steers the fetch after the one
// in flight. If that redirect arrives before the in-flight fetch completes,
// it is parked in a one-deep pending slot until the fetch lands.
module if_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       bpc,
  input  logic [31:0]       rpc,
  input  logic [31:0]       jpc,
  input  logic              nostall,
  if_stage_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       dpc4,
  output logic [31:0]       inst,
  output logic              d_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] buffer;
  logic        redir_pending;
  logic [31:0] redir_target;

  logic [31:0] pc4;
  logic        fc;
  logic [31:0] word;
  logic        capture;
  logic [31:0] sel_target;
  logic [31:0] next_pc;

  // Next-PC selection: a fresh redirect beats a parked one, which beats pc+4.
  always_comb begin
    pc4     = pc + 32'd4;
    fc      = (state == HOLD) || imem.imem_ack;
    word    = (state == HOLD) ? buffer : imem.imem_rdata;
    capture = nostall && d_valid && (pcsource != 2'b00);
    sel_target = pc4;
    case (pcsource)
      2'b01:   sel_target = bpc;
      2'b10:   sel_target = rpc;
      2'b11:   sel_target = jpc;
      default: sel_target = pc4;
    endcase
    if (capture)            next_pc = sel_target;
    else if (redir_pending) next_pc = redir_target;
    else                    next_pc = pc4;
  end

  // No request while the word sits in the buffer or while reset is held.
  assign imem.imem_req  = (state == FETCH) && !rst;
  assign imem.imem_addr = pc;

  // Fetch FSM, IF/ID register and redirect bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= 32'h0;
      inst          <= 32'h0;
      dpc4          <= 32'h0;
      d_valid       <= 1'b0;
      redir_pending <= 1'b0;
      redir_target  <= 32'h0;
      buffer        <= 32'h0;
      state         <= FETCH;
    end else if (nostall) begin
      if (fc) begin
        inst          <= word;
        dpc4          <= pc4;
        d_valid       <= 1'b1;
        pc            <= next_pc;
        redir_pending <= 1'b0;
        state         <= FETCH;
      end else begin
        // Decode moves on but nothing arrived: hand it a bubble.
        inst    <= 32'h0;
        d_valid <= 1'b0;
        if (capture) begin
          redir_pending <= 1'b1;
          redir_target  <= sel_target;
        end
      end
    end else if (state == FETCH && imem.imem_ack) begin
      // Decode is stalled; park the word so memory is not re-read.
      buffer <= imem.imem_rdata;
      state  <= HOLD;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage. The reference model is the architectural
// instruction stream with one delay slot: after the instruction at address a_i
// comes a_{i+1}, and a_{i+2} is the branch target if instruction i redirected
// when decode consumed it, else a_{i+1}+4. The stimulus pushes each expected
// address as soon as it is decided; the monitor pops one per instruction
// that enters decode.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        nostall;
  logic [31:0] pc, dpc4, inst;
  logic        d_valid;

  if_stage_if mif ();

  if_stage dut (
    .clk(clk), .rst(rst), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .nostall(nostall), .imem(mif), .pc(pc), .dpc4(dpc4), .inst(inst), .d_valid(d_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_tail;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    m_tail = 32'h4;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom % 4)
      0: return 32'h0000_0100;
      1: return 32'hFFFF_FFFC;
      2: return 32'hFFFF_FFF8;
      default: return {$urandom} & 32'hFFFF_FFFC;
    endcase
  endfunction

  // One stimulus cycle per negedge; expected stream advances whenever decode
  // consumes a real instruction.
  task automatic run_phase(input int n, input int ackpct, input int nspct);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      nostall  = (($urandom % 100) < nspct);
      mif.imem_ack   = mif.imem_req && (($urandom % 100) < ackpct);
      mif.imem_rdata = mif.imem_ack ? memw(mif.imem_addr) : $urandom;
      bpc = $urandom; rpc = $urandom; jpc = $urandom;
      pcsource = 2'b00;
      if (d_valid && nostall) begin
        if (($urandom % 4) == 0) begin
          pcsource = 2'($urandom_range(1, 3));
          t = pick_target();
          case (pcsource)
            2'b01:   bpc = t;
            2'b10:   rpc = t;
            default: jpc = t;
          endcase
          exp_q.push_back(t);
          m_tail = t;
        end else begin
          m_tail = m_tail + 32'd4;
          exp_q.push_back(m_tail);
        end
      end
    end
  endtask

  // Monitor: compare on every non-reset edge, 1 time unit after it.
  logic [31:0] p_pc = 0, p_dpc4 = 0, p_inst = 0;
  logic        p_dv = 0;
  always @(posedge clk) begin
    logic ns_q, rst_q;
    logic [31:0] a;
    ns_q  = nostall;
    rst_q = rst;
    #1;
    if (!rst_q) begin
      chk("imem_addr_eq_pc", mif.imem_addr, pc);
      if (ns_q) begin
        if (d_valid) begin
          if (exp_q.size() == 0) begin
            chk("stream_underflow", 32'd1, 32'd0);
          end else begin
            a = exp_q.pop_front();
            delivered++;
            chk("dpc4", dpc4, a + 32'd4);
            chk("inst", inst, memw(a));
          end
        end else begin
          chk("bubble_inst", inst, 32'h0);
        end
      end else begin
        chk("stall_pc", pc, p_pc);
        chk("stall_dpc4", dpc4, p_dpc4);
        chk("stall_inst", inst, p_inst);
        chk("stall_dvalid", {31'h0, d_valid}, {31'h0, p_dv});
      end
    end
    p_pc = pc; p_dpc4 = dpc4; p_inst = inst; p_dv = d_valid;
  end

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    rst = 1'b1; nostall = 1'($urandom); pcsource = 2'($urandom);
    mif.imem_ack = 1'b0; mif.imem_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_dpc4"}, dpc4, 32'h0);
    chk({tag, "_dvalid"}, {31'h0, d_valid}, 32'h0);
    chk({tag, "_req_in_rst"}, {31'h0, mif.imem_req}, 32'h0);
    rst = 1'b0; nostall = 1'b0; pcsource = 2'b00;
    model_reset();
    #1;
    chk({tag, "_req_after"}, {31'h0, mif.imem_req}, 32'h1);
    chk({tag, "_addr_after"}, mif.imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1; nostall = 1'b0; pcsource = 2'b00;
    bpc = 0; rpc = 0; jpc = 0;
    mif.imem_ack = 1'b0; mif.imem_rdata = 0;
    model_reset();
    reset_and_check("rst0");
    run_phase(300, 100, 100);
    run_phase(800, 100, 75);
    run_phase(800, 40, 80);
    run_phase(600, 25, 50);
    reset_and_check("rst1");
    run_phase(600, 60, 70);
    run_phase(100, 100, 100);
    chk("progress", {31'h0, (delivered > 1000)}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
